// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control FSM: state encoding, opcodes,
// trap cause codes and the packed control-output bundle.
// Ports: none (package).
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_JUMP,
    S_BEQ,
    S_AUIPC,
    S_LUI,
    S_TRAP
  } state_e;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [1:0] {
    TRAP_NONE    = 2'b00,
    TRAP_ILLEGAL = 2'b01,
    TRAP_TIMEOUT = 2'b10
  } trap_e;

  typedef struct packed {
    logic       branch;
    logic       pcupdate;
    logic       regwrite;
    logic       memwrite;
    logic       irwrite;
    logic       adrsrc;
    logic       mem_req;
    logic       retire;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

  // States that hold a memory request open until mem_ready.
  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// master: controller side (takes op/mem_ready, drives strobes, selects, trap_cause).
// slave: datapath side (drives op/mem_ready, observes everything else).
interface mc_ctrl_fsm_if;
  logic [6:0] op;
  logic       mem_ready;
  logic       branch;
  logic       pcupdate;
  logic       regwrite;
  logic       memwrite;
  logic       irwrite;
  logic       adrsrc;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic       mem_req;
  logic       retire;
  logic [1:0] trap_cause;

  modport master (
    input  op, mem_ready,
    output branch, pcupdate, regwrite, memwrite, irwrite, adrsrc,
           resultsrc, alusrca, alusrcb, aluop, mem_req, retire, trap_cause
  );

  modport slave (
    output op, mem_ready,
    input  branch, pcupdate, regwrite, memwrite, irwrite, adrsrc,
           resultsrc, alusrca, alusrcb, aluop, mem_req, retire, trap_cause
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts stalled request cycles, saturating at TIMEOUT.
// Latency: expired is a combinational compare of the registered count.
// Backpressure: none; clr has priority over inc. Ports: clk, rst, clr, inc, expired.
module mem_wait_timer #(
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT);

  logic [WAIT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != LIMIT)) begin
      // Saturate rather than wrap so a long stall can never look fresh.
      r_count <= r_count + WAIT_W'(1);
    end
  end

  assign expired = (r_count == LIMIT);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RISC-V style controller: sequences fetch/decode/execute/writeback.
// Latency: Moore outputs plus mem_ready-gated strobes; one state per cycle.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold until mem_ready, trap on timeout.
// Ports: clk, rst (async, active-high), bus (mc_ctrl_fsm_if.master).
module mc_ctrl_fsm #(
  parameter bit HANDSHAKE_EN = 1'b1,
  parameter int WAIT_W       = 4,
  parameter int TIMEOUT      = 15
) (
  input logic          clk,
  input logic          rst,
  mc_ctrl_fsm_if.master bus
);
  import mc_pkg::*;

  state_e r_state;
  state_e w_next;
  trap_e  r_trap_cause;
  trap_e  w_cause;
  ctrl_t  w_ctrl;
  logic   w_ready;
  logic   w_expired;
  logic   w_clr;
  logic   w_inc;

  // Without handshaking every access completes in its first cycle.
  assign w_ready = HANDSHAKE_EN ? bus.mem_ready : 1'b1;

  // Any state change re-arms the timer, which covers every entry into a
  // request state; it only counts cycles where a request is stalled.
  assign w_clr = (w_next != r_state);
  assign w_inc = w_ctrl.mem_req && !w_ready;

  mem_wait_timer #(
    .WAIT_W (WAIT_W),
    .TIMEOUT(TIMEOUT)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_clr),
    .inc    (w_inc),
    .expired(w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Cause is latched only on entry, so TRAP keeps it until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trap_cause <= TRAP_NONE;
    end else if ((r_state != S_TRAP) && (w_next == S_TRAP)) begin
      r_trap_cause <= w_cause;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_cause = TRAP_NONE;
    case (r_state)
      S_FETCH: begin
        // mem_ready beats the timeout on the same cycle.
        if (w_ready) begin
          w_next = S_DECODE;
        end else if (w_expired) begin
          w_next  = S_TRAP;
          w_cause = TRAP_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (bus.op)
          OP_RTYPE:                  w_next = S_EXEC_R;
          OP_ITYPE:                  w_next = S_EXEC_I;
          OP_LOAD, OP_STORE, OP_JALR: w_next = S_MEMADR;
          OP_BEQ:                    w_next = S_BEQ;
          OP_JAL:                    w_next = S_JUMP;
          OP_AUIPC:                  w_next = S_AUIPC;
          OP_LUI:                    w_next = S_LUI;
          default: begin
            w_next  = S_TRAP;
            w_cause = TRAP_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        case (bus.op)
          OP_LOAD:  w_next = S_MEMREAD;
          OP_STORE: w_next = S_MEMWRITE;
          OP_JALR:  w_next = S_JUMP;
          default: begin
            // Only reachable if the IR changed under us; treat as illegal.
            w_next  = S_TRAP;
            w_cause = TRAP_ILLEGAL;
          end
        endcase
      end
      S_MEMREAD: begin
        if (w_ready) begin
          w_next = S_MEMWB;
        end else if (w_expired) begin
          w_next  = S_TRAP;
          w_cause = TRAP_TIMEOUT;
        end
      end
      S_MEMWRITE: begin
        if (w_ready) begin
          w_next = S_FETCH;
        end else if (w_expired) begin
          w_next  = S_TRAP;
          w_cause = TRAP_TIMEOUT;
        end
      end
      S_EXEC_R, S_EXEC_I, S_JUMP, S_AUIPC: w_next = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ, S_LUI:     w_next = S_FETCH;
      S_TRAP:                             w_next = S_TRAP;
      default:                            w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    if (rst) begin
      // Strobes off during reset, selects parked at their fetch values.
      w_ctrl.resultsrc = 2'b10;
      w_ctrl.alusrcb   = 2'b10;
    end else begin
      w_ctrl.mem_req = is_mem_state(r_state);
      case (r_state)
        S_FETCH: begin
          w_ctrl.pcupdate  = w_ready;
          w_ctrl.irwrite   = w_ready;
          w_ctrl.resultsrc = 2'b10;
          w_ctrl.alusrcb   = 2'b10;
        end
        S_DECODE, S_AUIPC: begin
          w_ctrl.alusrca = 2'b01;
          w_ctrl.alusrcb = 2'b01;
        end
        S_MEMADR: begin
          w_ctrl.alusrca = 2'b10;
          w_ctrl.alusrcb = 2'b01;
        end
        S_MEMREAD: begin
          w_ctrl.adrsrc = 1'b1;
        end
        S_MEMWRITE: begin
          w_ctrl.adrsrc   = 1'b1;
          w_ctrl.memwrite = w_ready;
          w_ctrl.retire   = w_ready;
        end
        S_MEMWB: begin
          w_ctrl.regwrite  = 1'b1;
          w_ctrl.resultsrc = 2'b01;
          w_ctrl.retire    = 1'b1;
        end
        S_ALUWB: begin
          w_ctrl.regwrite = 1'b1;
          w_ctrl.retire   = 1'b1;
        end
        S_LUI: begin
          w_ctrl.regwrite  = 1'b1;
          w_ctrl.resultsrc = 2'b11;
          w_ctrl.retire    = 1'b1;
        end
        S_EXEC_R: begin
          w_ctrl.alusrca = 2'b10;
          w_ctrl.aluop   = 2'b10;
        end
        S_EXEC_I: begin
          w_ctrl.alusrca = 2'b10;
          w_ctrl.alusrcb = 2'b01;
          w_ctrl.aluop   = 2'b10;
        end
        S_JUMP: begin
          w_ctrl.pcupdate = 1'b1;
          w_ctrl.alusrca  = 2'b01;
          w_ctrl.alusrcb  = 2'b10;
        end
        S_BEQ: begin
          w_ctrl.branch  = 1'b1;
          w_ctrl.alusrca = 2'b10;
          w_ctrl.aluop   = 2'b01;
          w_ctrl.retire  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.branch     = w_ctrl.branch;
  assign bus.pcupdate   = w_ctrl.pcupdate;
  assign bus.regwrite   = w_ctrl.regwrite;
  assign bus.memwrite   = w_ctrl.memwrite;
  assign bus.irwrite    = w_ctrl.irwrite;
  assign bus.adrsrc     = w_ctrl.adrsrc;
  assign bus.resultsrc  = w_ctrl.resultsrc;
  assign bus.alusrca    = w_ctrl.alusrca;
  assign bus.alusrcb    = w_ctrl.alusrcb;
  assign bus.aluop      = w_ctrl.aluop;
  assign bus.mem_req    = w_ctrl.mem_req;
  assign bus.retire     = w_ctrl.retire;
  assign bus.trap_cause = r_trap_cause;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-instruction phase plans checked
// cycle by cycle against expected output vectors, plus directed corner cases.
// Ports: none (top-level bench).
module tb_mc_ctrl_fsm;
  import mc_pkg::*;

  typedef enum int {
    P_FETCH, P_DEC, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXR, P_EXI,
    P_ALUWB, P_JUMP, P_BEQ, P_AUIPC, P_LUI, P_TRAP, P_RST
  } ph_t;

  typedef struct {
    ph_t  ph;
    logic rdy;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  step_t plan[$];
  logic [6:0] legal_ops [0:8] = '{OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_JALR,
                                  OP_BEQ, OP_JAL, OP_AUIPC, OP_LUI};

  mc_ctrl_fsm_if bus();
  mc_ctrl_fsm_if bus_nh();

  mc_ctrl_fsm #(.HANDSHAKE_EN(1'b1), .WAIT_W(4), .TIMEOUT(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  mc_ctrl_fsm #(.HANDSHAKE_EN(1'b0), .WAIT_W(4), .TIMEOUT(15)) dut_nh (
    .clk(clk), .rst(rst), .bus(bus_nh)
  );

  always #5 clk = ~clk;

  // {branch,pcupdate,regwrite,memwrite,irwrite,adrsrc,mem_req,retire,
  //  resultsrc,alusrca,alusrcb,aluop,trap_cause}
  logic [17:0] obs, obs_nh;
  assign obs = {bus.branch, bus.pcupdate, bus.regwrite, bus.memwrite, bus.irwrite,
                bus.adrsrc, bus.mem_req, bus.retire, bus.resultsrc, bus.alusrca,
                bus.alusrcb, bus.aluop, bus.trap_cause};
  assign obs_nh = {bus_nh.branch, bus_nh.pcupdate, bus_nh.regwrite, bus_nh.memwrite,
                   bus_nh.irwrite, bus_nh.adrsrc, bus_nh.mem_req, bus_nh.retire,
                   bus_nh.resultsrc, bus_nh.alusrca, bus_nh.alusrcb, bus_nh.aluop,
                   bus_nh.trap_cause};

  // Expected outputs for each phase, straight from the per-state output table.
  function automatic logic [17:0] exp_out(ph_t ph, logic rdy, logic [1:0] cause);
    logic br, pc, rw, mw, ir, ad, mr, rt;
    logic [1:0] rs, aa, ab, ao, tc;
    {br, pc, rw, mw, ir, ad, mr, rt} = '0;
    {rs, aa, ab, ao, tc} = '0;
    case (ph)
      P_RST:    begin rs = 2'b10; ab = 2'b10; end
      P_FETCH:  begin mr = 1; pc = rdy; ir = rdy; rs = 2'b10; ab = 2'b10; end
      P_DEC:    begin aa = 2'b01; ab = 2'b01; end
      P_AUIPC:  begin aa = 2'b01; ab = 2'b01; end
      P_MEMADR: begin aa = 2'b10; ab = 2'b01; end
      P_MEMRD:  begin mr = 1; ad = 1; end
      P_MEMWR:  begin mr = 1; ad = 1; mw = rdy; rt = rdy; end
      P_MEMWB:  begin rw = 1; rs = 2'b01; rt = 1; end
      P_ALUWB:  begin rw = 1; rt = 1; end
      P_LUI:    begin rw = 1; rs = 2'b11; rt = 1; end
      P_EXR:    begin aa = 2'b10; ao = 2'b10; end
      P_EXI:    begin aa = 2'b10; ab = 2'b01; ao = 2'b10; end
      P_JUMP:   begin pc = 1; aa = 2'b01; ab = 2'b10; end
      P_BEQ:    begin br = 1; aa = 2'b10; ao = 2'b01; rt = 1; end
      P_TRAP:   begin tc = cause; end
      default:  ;
    endcase
    return {br, pc, rw, mw, ir, ad, mr, rt, rs, aa, ab, ao, tc};
  endfunction

  function automatic logic is_mem_ph(ph_t ph);
    return (ph == P_FETCH) || (ph == P_MEMRD) || (ph == P_MEMWR);
  endfunction

  // Path of one instruction: fw stalled fetch cycles, mw stalled memory cycles.
  function automatic void plan_instr(logic [6:0] op, int fw, int mw);
    plan.delete();
    repeat (fw) plan.push_back('{P_FETCH, 1'b0});
    plan.push_back('{P_FETCH, 1'b1});
    plan.push_back('{P_DEC, 1'b0});
    case (op)
      OP_RTYPE: begin plan.push_back('{P_EXR, 1'b0}); plan.push_back('{P_ALUWB, 1'b0}); end
      OP_ITYPE: begin plan.push_back('{P_EXI, 1'b0}); plan.push_back('{P_ALUWB, 1'b0}); end
      OP_LOAD: begin
        plan.push_back('{P_MEMADR, 1'b0});
        repeat (mw) plan.push_back('{P_MEMRD, 1'b0});
        plan.push_back('{P_MEMRD, 1'b1});
        plan.push_back('{P_MEMWB, 1'b0});
      end
      OP_STORE: begin
        plan.push_back('{P_MEMADR, 1'b0});
        repeat (mw) plan.push_back('{P_MEMWR, 1'b0});
        plan.push_back('{P_MEMWR, 1'b1});
      end
      OP_JALR: begin
        plan.push_back('{P_MEMADR, 1'b0});
        plan.push_back('{P_JUMP, 1'b0});
        plan.push_back('{P_ALUWB, 1'b0});
      end
      OP_BEQ:   plan.push_back('{P_BEQ, 1'b0});
      OP_JAL:   begin plan.push_back('{P_JUMP, 1'b0}); plan.push_back('{P_ALUWB, 1'b0}); end
      OP_AUIPC: begin plan.push_back('{P_AUIPC, 1'b0}); plan.push_back('{P_ALUWB, 1'b0}); end
      OP_LUI:   plan.push_back('{P_LUI, 1'b0});
      default:  plan.push_back('{P_TRAP, 1'b0});
    endcase
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.op = OP_RTYPE; bus.mem_ready = 1'b0;
    bus_nh.op = OP_RTYPE; bus_nh.mem_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== exp_out(P_RST, 1'b0, 2'b00)) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, exp_out(P_RST, 1'b0, 2'b00));
    end
    n_checks++;
    if (obs_nh !== exp_out(P_RST, 1'b0, 2'b00)) begin
      n_fail++; $display("FAIL reset_outputs_nh: got %h expected %h", obs_nh, exp_out(P_RST, 1'b0, 2'b00));
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== exp_out(P_FETCH, 1'b0, 2'b00)) begin
      n_fail++; $display("FAIL first_fetch: got %h expected %h", obs, exp_out(P_FETCH, 1'b0, 2'b00));
    end
    n_checks++;
    if (obs_nh !== exp_out(P_FETCH, 1'b1, 2'b00)) begin
      n_fail++; $display("FAIL first_fetch_nh: got %h expected %h", obs_nh, exp_out(P_FETCH, 1'b1, 2'b00));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rtype_nohs();
    int ret = 0;
    bus_nh.op = OP_RTYPE;
    bus_nh.mem_ready = 1'b0;
    apply_reset();
    plan_instr(OP_RTYPE, 0, 0);
    plan.push_back('{P_FETCH, 1'b1});
    foreach (plan[i]) begin
      @(negedge clk);
      n_checks++;
      if (obs_nh !== exp_out(plan[i].ph, 1'b1, 2'b00)) begin
        n_fail++; $display("FAIL rtype_nohs step %0d: got %h expected %h", i, obs_nh, exp_out(plan[i].ph, 1'b1, 2'b00));
      end
      if (i < 4 && obs_nh[10] === 1'b1) ret++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (ret !== 1) begin
      n_fail++; $display("FAIL rtype_nohs_retire: got %0d required 1", ret);
    end
  endtask

  task automatic test_load_wait();
    int mreq = 0, rw = 0;
    bus.op = OP_LOAD;
    apply_reset();
    plan_instr(OP_LOAD, 0, 3);
    foreach (plan[i]) begin
      bus.mem_ready = is_mem_ph(plan[i].ph) ? plan[i].rdy : 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if (obs !== exp_out(plan[i].ph, plan[i].rdy, 2'b00)) begin
        n_fail++; $display("FAIL load_wait step %0d: got %h expected %h", i, obs, exp_out(plan[i].ph, plan[i].rdy, 2'b00));
      end
      if (plan[i].ph == P_MEMRD && bus.mem_req === 1'b1) mreq++;
      if (bus.regwrite === 1'b1) rw++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (mreq !== 4 || rw !== 1 || bus.trap_cause !== 2'b00) begin
      n_fail++; $display("FAIL load_summary: mem_req=%0d regwrite=%0d trap=%b required 4 1 00", mreq, rw, bus.trap_cause);
    end
  endtask

  task automatic test_store();
    int mw = 0;
    bus.op = OP_STORE;
    apply_reset();
    plan_instr(OP_STORE, 1, 2);
    plan.push_back('{P_FETCH, 1'b0});
    foreach (plan[i]) begin
      bus.mem_ready = is_mem_ph(plan[i].ph) ? plan[i].rdy : 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if (obs !== exp_out(plan[i].ph, plan[i].rdy, 2'b00)) begin
        n_fail++; $display("FAIL store step %0d: got %h expected %h", i, obs, exp_out(plan[i].ph, plan[i].rdy, 2'b00));
      end
      if (bus.memwrite === 1'b1) begin
        mw++;
        n_checks++;
        if (bus.mem_ready !== 1'b1) begin
          n_fail++; $display("FAIL store_memwrite_ready: memwrite without mem_ready");
        end
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (mw !== 1) begin
      n_fail++; $display("FAIL store_memwrite_count: got %0d required 1", mw);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op_sel;
      int ret = 0;
      op_sel = legal_ops[$urandom_range(0, 8)];
      plan_instr(op_sel, $urandom_range(0, 3), $urandom_range(0, 3));
      bus.op = op_sel;
      foreach (plan[i]) begin
        bus.mem_ready = is_mem_ph(plan[i].ph) ? plan[i].rdy : 1'($urandom_range(0, 1));
        @(negedge clk);
        n_checks++;
        if (obs !== exp_out(plan[i].ph, plan[i].rdy, 2'b00)) begin
          n_fail++; $display("FAIL random op=%b step %0d: got %h expected %h", op_sel, i, obs, exp_out(plan[i].ph, plan[i].rdy, 2'b00));
        end
        if (bus.retire === 1'b1) ret++;
        @(posedge clk);
        #1;
      end
      n_checks++;
      if (ret !== 1) begin
        n_fail++; $display("FAIL random_retire op=%b: got %0d required 1", op_sel, ret);
      end
    end
  endtask

  task automatic test_illegal();
    bus.op = 7'b1111111;
    apply_reset();
    plan_instr(7'b1111111, 0, 0);
    repeat (19) plan.push_back('{P_TRAP, 1'b0});
    foreach (plan[i]) begin
      bus.mem_ready = is_mem_ph(plan[i].ph) ? plan[i].rdy : 1'($urandom_range(0, 1));
      if (i > 3) bus.op = legal_ops[$urandom_range(0, 8)];
      @(negedge clk);
      n_checks++;
      if (obs !== exp_out(plan[i].ph, plan[i].rdy, 2'b01)) begin
        n_fail++; $display("FAIL illegal step %0d: got %h expected %h", i, obs, exp_out(plan[i].ph, plan[i].rdy, 2'b01));
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== exp_out(P_RST, 1'b0, 2'b00)) begin
      n_fail++; $display("FAIL illegal_reset: got %h expected %h", obs, exp_out(P_RST, 1'b0, 2'b00));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== exp_out(P_FETCH, 1'b0, 2'b00)) begin
      n_fail++; $display("FAIL illegal_refetch: got %h expected %h", obs, exp_out(P_FETCH, 1'b0, 2'b00));
    end
    @(posedge clk);
    #1;
  endtask

  // With TIMEOUT=3, fetch cycles 0..3 stall and cycle 3 is the deciding one.
  task automatic test_timeout();
    bus.op = OP_RTYPE;
    apply_reset();
    for (int k = 0; k < 24; k++) begin
      ph_t ph;
      ph = (k < 4) ? P_FETCH : P_TRAP;
      bus.mem_ready = (k < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if (obs !== exp_out(ph, 1'b0, 2'b10)) begin
        n_fail++; $display("FAIL timeout cycle %0d: got %h expected %h", k, obs, exp_out(ph, 1'b0, 2'b10));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_timeout_boundary();
    bus.op = OP_LUI;
    apply_reset();
    plan_instr(OP_LUI, 3, 0);
    plan.push_back('{P_FETCH, 1'b0});
    foreach (plan[i]) begin
      bus.mem_ready = is_mem_ph(plan[i].ph) ? plan[i].rdy : 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if (obs !== exp_out(plan[i].ph, plan[i].rdy, 2'b00)) begin
        n_fail++; $display("FAIL timeout_boundary step %0d: got %h expected %h", i, obs, exp_out(plan[i].ph, plan[i].rdy, 2'b00));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_rst_mid_write();
    bus.op = OP_STORE;
    apply_reset();
    plan_instr(OP_STORE, 0, 0);
    foreach (plan[i]) begin
      bus.mem_ready = is_mem_ph(plan[i].ph) ? plan[i].rdy : 1'b0;
      @(negedge clk);
      n_checks++;
      if (obs !== exp_out(plan[i].ph, plan[i].rdy, 2'b00)) begin
        n_fail++; $display("FAIL rst_mid_write step %0d: got %h expected %h", i, obs, exp_out(plan[i].ph, plan[i].rdy, 2'b00));
      end
      if (i == plan.size() - 1) begin
        // Reset lands mid-cycle while memwrite is high.
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== exp_out(P_RST, 1'b0, 2'b00)) begin
          n_fail++; $display("FAIL rst_mid_write_drop: got %h expected %h", obs, exp_out(P_RST, 1'b0, 2'b00));
        end
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== exp_out(P_FETCH, 1'b0, 2'b00)) begin
      n_fail++; $display("FAIL rst_mid_write_fetch: got %h expected %h", obs, exp_out(P_FETCH, 1'b0, 2'b00));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_rtype_nohs();
    test_load_wait();
    test_store();
    test_random();
    test_illegal();
    test_timeout();
    test_timeout_boundary();
    test_rst_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have parameter HANDSHAKE_EN, default 1; 1 = wait on mem_ready, 0 = mem_ready internally forced to 1.
REQ-002 SHALL have parameter WAIT_W, default 4; width of the memory wait counter.
REQ-003 SHALL have parameter TIMEOUT, default 15; wait cycles before a bus-timeout trap, legal range 1..2^WAIT_W-1.
REQ-004 SHALL have port clk, input, 1 bit; sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port op, input, 7 bits; opcode of the instruction register.
REQ-007 SHALL have port mem_ready, input, 1 bit; memory has completed the current access.
REQ-008 SHALL have ports branch, pcupdate, regwrite, memwrite, irwrite, adrsrc, outputs, 1 bit each; datapath strobes and address select.
REQ-009 SHALL have ports resultsrc, alusrca, alusrcb, aluop, outputs, 2 bits each; datapath mux selects and ALU op class.
REQ-010 SHALL have port mem_req, output, 1 bit; memory access request.
REQ-011 SHALL have port retire, output, 1 bit; one-cycle pulse on the final cycle of each completed instruction.
REQ-012 SHALL have port trap_cause, output, 2 bits; 00 none, 01 illegal opcode, 10 bus timeout.

Function
REQ-013 SHALL implement states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, JUMP, BEQ, AUIPC, LUI, TRAP.
REQ-014 SHALL transition FETCH->DECODE only when mem_ready=1; otherwise stay in FETCH.
REQ-015 SHALL decode op in DECODE: 0110011->EXEC_R, 0010011->EXEC_I, 0000011/0100011/1100111->MEMADR, 1100011->BEQ, 1101111->JUMP, 0010111->AUIPC, 0110111->LUI, any other->TRAP with cause 01.
REQ-016 SHALL transition MEMADR->MEMREAD for 0000011, MEMADR->MEMWRITE for 0100011, and MEMADR->JUMP for 1100111.
REQ-017 SHALL hold MEMREAD and MEMWRITE until mem_ready=1, then go MEMREAD->MEMWB and MEMWRITE->FETCH.
REQ-018 SHALL transition EXEC_R, EXEC_I, JUMP, and AUIPC to ALUWB, and SHALL transition MEMWB, ALUWB, BEQ, and LUI to FETCH.
REQ-019 SHALL assert mem_req=1 in FETCH, MEMREAD, and MEMWRITE, and 0 in all other states.
REQ-020 SHALL gate pcupdate and irwrite in FETCH, and memwrite in MEMWRITE, with mem_ready, so that each pulses exactly once per access.
REQ-021 SHALL drive FETCH selects as resultsrc=10, alusrca=00, alusrcb=10, aluop=00, adrsrc=0.
REQ-022 SHALL drive DECODE and AUIPC selects as alusrca=01, alusrcb=01, aluop=00.
REQ-023 SHALL drive MEMADR selects as alusrca=10, alusrcb=01, aluop=00.
REQ-024 SHALL drive adrsrc=1 in MEMREAD and MEMWRITE, adrsrc=0 elsewhere.
REQ-025 SHALL drive MEMWB as regwrite=1, resultsrc=01; ALUWB as regwrite=1, resultsrc=00; LUI as regwrite=1, resultsrc=11.
REQ-026 SHALL drive EXEC_R as alusrca=10, alusrcb=00, aluop=10, and EXEC_I as alusrca=10, alusrcb=01, aluop=10.
REQ-027 SHALL drive JUMP as pcupdate=1, alusrca=01, alusrcb=10, resultsrc=00; and BEQ as branch=1, alusrca=10, alusrcb=00, aluop=01.
REQ-028 SHALL drive unlisted outputs as 0 in every state; no X values shall be driven.
REQ-029 SHALL pulse retire=1 in MEMWB, ALUWB, BEQ, LUI, and MEMWRITE-with-mem_ready.
REQ-030 SHALL clear the wait counter on entering any mem_req state and increment it each cycle with mem_req=1 and mem_ready=0.
REQ-031 SHALL enter TRAP with cause 10 when the wait counter equals TIMEOUT and mem_ready=0; mem_ready on that same cycle wins and suppresses the trap.
REQ-032 SHALL make TRAP sticky until rst: all strobes and mem_req held 0, and trap_cause held.
REQ-033 SHALL never let the wait counter wrap; it saturates at TIMEOUT.

Reset
REQ-034 SHALL, on rst assertion at any cycle including mid-access, force state=FETCH, wait counter=0, and trap_cause=00 asynchronously.
REQ-035 SHALL force all strobes (pcupdate, irwrite, regwrite, memwrite, branch, mem_req, retire) to 0 while rst=1, with selects at FETCH values.
REQ-036 SHALL start the first fetch request on the first clk edge after rst deasserts.

Structure
REQ-037 SHALL place state encodings, opcode constants, and trap_cause codes in shared package mc_pkg.
REQ-038 SHALL factor the wait/timeout counter as sub-module mem_wait_timer (inputs clr, inc; output expired).

Verification
REQ-039 SHALL cover R-type add with HANDSHAKE_EN=0: op=0110011 -> FETCH, DECODE, EXEC_R, ALUWB; 4 cycles; retire pulses once in ALUWB.
REQ-040 SHALL cover a load with mem_ready low for 3 cycles in MEMREAD: mem_req held 4 cycles, regwrite in MEMWB only, no trap.
REQ-041 SHALL cover a store: memwrite is a single pulse coincident with mem_ready, followed by FETCH next cycle.
REQ-042 SHALL cover an illegal opcode: op=1111111 -> TRAP after DECODE, trap_cause=01, all strobes 0 for 20 cycles, then rst clears to FETCH.
REQ-043 SHALL cover a timeout: TIMEOUT=3 with mem_ready stuck 0 in FETCH -> trap_cause=10 after 3 wait cycles; mem_ready=1 exactly on the third cycle -> no trap.
REQ-044 SHALL cover rst asserted mid-MEMWRITE: memwrite drops immediately and state=FETCH.
